// File: rtl/light_pkg.sv
// Shared constants and lamp-state encoding for the five-way room light controller.
package light_pkg;

  localparam int unsigned     N_SW_BOARD             = 5;
  localparam logic [2:0]      LAST_SW_NONE           = 3'd7;

  // Defaults for the 100 MHz board clock: 10 ms debounce, 30 s idle auto-off
  localparam int unsigned     DEBOUNCE_CYCLES_100MHZ = 1000000;
  localparam longint unsigned TIMEOUT_CYCLES_100MHZ  = 64'd3000000000;

  typedef enum logic {
    LAMP_OFF = 1'b0,
    LAMP_ON  = 1'b1
  } lamp_state_t;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle pulse on every accepted level change.
module sw_debounce
  import light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic edge_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switch into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      level    <= 1'b0;
      edge_evt <= 1'b0;
    end else begin
      edge_evt <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level    <= sync2;
        cnt      <= '0;
        edge_evt <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/five_way_light_ctrl.sv
// Multi-way room light: every debounced switch edge is a toggle request, an odd
// number of simultaneous edges flips the lamp.
// Optional idle auto-off is compiled in with macro LIGHT_AUTO_OFF_EN.
module five_way_light_ctrl
  import light_pkg::*;
#(
  parameter int unsigned     N_SW            = N_SW_BOARD,
  parameter int unsigned     DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
  parameter longint unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_100MHZ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic            led,
  output logic [2:0]      last_sw,
  output logic            toggle,
  output logic            timeout
);

  // last_sw reserves 3'd7 for "none", so at most 7 channels fit
  if (N_SW > 7) begin : g_bad_nsw
    $error("N_SW must be <= 7");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  lamp_state_t     state;
  logic [N_SW-1:0] edges;
  logic            any_edge_c;
  logic            odd_c;
  logic            expire_c;
  logic [2:0]      first_c;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw     (sw[g]),
      .edge_evt(edges[g])
    );
  end

  assign any_edge_c = |edges;
  assign odd_c      = ^edges;
  assign led        = (state == LAMP_ON);

  // Lowest-index channel with an edge this cycle
  always_comb begin
    first_c = LAST_SW_NONE;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (edges[i]) first_c = 3'(i);
    end
  end

`ifdef LIGHT_AUTO_OFF_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMR_W-1:0] idle_cnt;

  // Switch activity always wins over an expiring timer
  assign expire_c = (state == LAMP_ON) && !any_edge_c &&
                    (idle_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  // Idle time while the lamp is on, restarted by any switch edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (any_edge_c || state == LAMP_OFF || expire_c) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TMR_W'(1);
    end
  end
`else
  assign expire_c = 1'b0;
`endif

  // Lamp state, last acting switch and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LAMP_OFF;
      last_sw <= LAST_SW_NONE;
      toggle  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      toggle  <= 1'b0;
      timeout <= 1'b0;
      if (any_edge_c) last_sw <= first_c;
      if (odd_c) begin
        state  <= (state == LAMP_ON) ? LAMP_OFF : LAMP_ON;
        toggle <= 1'b1;
      end else if (expire_c) begin
        state   <= LAMP_OFF;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_five_way_light_ctrl.sv
// Directed bench for five_way_light_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_five_way_light_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] sw;
  logic       led;
  logic [2:0] last_sw;
  logic       toggle;
  logic       timeout;

  int n_pass;
  int n_total;

  five_way_light_ctrl #(
    .N_SW           (5),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64'd20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .led    (led),
    .last_sw(last_sw),
    .toggle (toggle),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic e_led, input logic e_tog,
                            input logic [2:0] e_last, input logic e_to);
    check({tag, ".led"},     32'(led),     32'(e_led));
    check({tag, ".toggle"},  32'(toggle),  32'(e_tog));
    check({tag, ".last_sw"}, 32'(last_sw), 32'(e_last));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clean_reset();
    rst = 1'b1;
    sw  = 5'b00000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_outs("clean_rst", 1'b0, 1'b0, 3'd7, 1'b0);
  endtask

  // Apply a switch pattern; outputs must hold for 6 cycles, change on the 7th
  task automatic apply(input string tag, input logic [4:0] new_sw,
                       input logic old_led, input logic [2:0] old_last,
                       input logic new_led, input logic new_tog, input logic [2:0] new_last);
    sw = new_sw;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_outs({tag, ".wait"}, old_led, 1'b0, old_last, 1'b0);
    end
    tick();
    check_outs({tag, ".hit"}, new_led, new_tog, new_last, 1'b0);
    tick();
    check_outs({tag, ".after"}, new_led, 1'b0, new_last, 1'b0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    sw      = 5'b00000;
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-cycle with three switches already up
    #3;
    sw  = 5'b10101;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 3'd7, 1'b0);
    tick();
    tick();
    check_outs("rst_hold", 1'b0, 1'b0, 3'd7, 1'b0);
    rst = 1'b0;
    apply("rst_k3", 5'b10101, 1'b0, 3'd7, 1'b1, 1'b1, 3'd0);

    // Single switch toggles
    clean_reset();
    apply("sw3_on",  5'b01000, 1'b0, 3'd7, 1'b1, 1'b1, 3'd3);
    apply("sw1_off", 5'b01010, 1'b1, 3'd3, 1'b0, 1'b1, 3'd1);

    // Three-cycle glitch on sw[2] never propagates
    sw = 5'b01110;
    tick();
    tick();
    tick();
    sw = 5'b01010;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs("glitch", 1'b0, 1'b0, 3'd1, 1'b0);
    end

    // Two simultaneous edges cancel, last_sw still loads
    apply("simul", 5'b11011, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0);

    // Lamp on via sw[1], then idle
    apply("sw1_on", 5'b11001, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1);
`ifdef LIGHT_AUTO_OFF_EN
    // "after" of apply is idle cycle 1; cycles 2..19 stay on
    for (int i = 2; i <= 19; i++) begin
      tick();
      check_outs("idle_on", 1'b1, 1'b0, 3'd1, 1'b0);
    end
    tick();
    check_outs("auto_off", 1'b0, 1'b0, 3'd1, 1'b1);
    tick();
    check_outs("auto_off_after", 1'b0, 1'b0, 3'd1, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check_outs("stay_on", 1'b1, 1'b0, 3'd1, 1'b0);
    end
`endif

    // Reset in the middle of a debounce discards its progress
    clean_reset();
    sw = 5'b00100;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_outs("mid_rst", 1'b0, 1'b0, 3'd7, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    apply("post_rst", 5'b00100, 1'b0, 3'd7, 1'b1, 1'b1, 3'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
